busca_instrucao: RTL and testbench

Instruction fetch/issue unit on the opposite side of the control-unit interface. It owns PC and IR, fetches 16-bit instructions from instruction memory over a req/ack handshake, presents the opcode field to the control unit, and applies the control unit's PC-write decisions (EscCP, EscCondCP, FonteCP). It sits between instruction memory and the control/datapath and sequences one instruction at a time.

---
 rtl/busca_instrucao_if.sv | 24 ++
 rtl/busca_instrucao.sv | 98 +++++++++
 tb/tb_busca_instrucao.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/busca_instrucao_if.sv
// rtl/busca_instrucao_if.sv - instruction memory fetch handshake (req/ack, addr/rdata)
interface busca_instrucao_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/busca_instrucao.sv
// rtl/busca_instrucao.sv - instruction fetch/issue unit owning PC and IR
module busca_instrucao #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  busca_instrucao_if.master mem,
  output logic [DATA_W-1:0] instr,
  output logic [3:0]        opcode,
  output logic              instr_valid,
  input  logic              EscCP,
  input  logic              EscCondCP,
  input  logic [1:0]        FonteCP,
  input  logic              zero,
  input  logic [ADDR_W-1:0] ula_result,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign pc_inc = pc_q + ADDR_W'(1);

  // Reserved source 11 falls back to sequential execution.
  always_comb begin
    next_src = pc_inc;
    case (FonteCP)
      2'b01:   next_src = ula_result;
      2'b10:   next_src = ir_q[ADDR_W-1:0];
      default: next_src = pc_inc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = (ir_q[DATA_W-1 -: 4] == HALT_OP) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (!stall) begin
          state_d = S_FETCH;
          // Conditional write takes priority; a not-taken branch still advances.
          if (EscCondCP)
            pc_d = zero ? next_src : pc_inc;
          else if (EscCP)
            pc_d = next_src;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem.mem_req  = (state_q == S_FETCH);
  assign mem.mem_addr = pc_q;
  assign instr        = ir_q;
  assign opcode       = ir_q[DATA_W-1 -: 4];
  assign instr_valid  = (state_q == S_ISSUE);
  assign halted       = (state_q == S_HALT);
  assign pc           = pc_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// tb/tb_busca_instrucao.sv - self-checking bench for busca_instrucao
module tb_busca_instrucao;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic        instr_valid;
  logic        EscCP = 1'b0;
  logic        EscCondCP = 1'b0;
  logic [1:0]  FonteCP = 2'b00;
  logic        zero = 1'b0;
  logic [7:0]  ula_result = 8'h00;
  logic        stall = 1'b0;
  logic [7:0]  pc;
  logic        halted;

  int n_assert = 0;
  int n_fail   = 0;

  int          exp_pc = 0;
  logic [15:0] exp_ir = 16'h0000;

  busca_instrucao_if #(.DATA_W(16), .ADDR_W(8)) mem_bus ();

  busca_instrucao #(.DATA_W(16), .ADDR_W(8), .RESET_PC(8'h00), .HALT_OP(4'hF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem         (mem_bus.master),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .EscCP       (EscCP),
    .EscCondCP   (EscCondCP),
    .FonteCP     (FonteCP),
    .zero        (zero),
    .ula_result  (ula_result),
    .stall       (stall),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Architectural PC rule, expressed with plain modulo arithmetic.
  function automatic int model_pc(input int cur, input logic [15:0] ir, input logic esc,
                                  input logic cond, input logic [1:0] src, input logic z,
                                  input logic [7:0] ula);
    int seq;
    int tgt;
    seq = (cur + 1) % 256;
    if (src == 2'd1)      tgt = int'(ula);
    else if (src == 2'd2) tgt = int'(ir) % 256;
    else                  tgt = seq;
    if (cond)     return z ? tgt : seq;
    else if (esc) return tgt;
    else          return cur;
  endfunction

  // Called at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH (or after halt checks).
  task automatic run_instr(input int waits, input logic [15:0] data, input logic esc,
                           input logic cond, input logic [1:0] src, input logic z,
                           input logic [7:0] ula, input int stalls, input logic ack_exec);
    for (int i = 0; i <= waits; i++) begin
      check("fetch_req", mem_bus.mem_req, 1'b1);
      check("fetch_addr", mem_bus.mem_addr, exp_pc[7:0]);
      check("fetch_ir_stable", instr, exp_ir);
      check("fetch_no_valid", instr_valid, 1'b0);
      mem_bus.mem_ack   = (i == waits);
      mem_bus.mem_rdata = (i == waits) ? data : 16'($urandom);
      @(negedge clk);
    end
    exp_ir = data;
    mem_bus.mem_ack   = ack_exec;
    mem_bus.mem_rdata = 16'($urandom);
    check("issue_valid", instr_valid, 1'b1);
    check("issue_instr", instr, exp_ir);
    check("issue_opcode", opcode, exp_ir[15:12]);
    check("issue_req", mem_bus.mem_req, 1'b0);
    check("issue_halted", halted, 1'b0);
    if (data[15:12] == 4'hF) begin
      EscCP = 1'b1;
      FonteCP = 2'b01;
      ula_result = 8'hA5;
      @(negedge clk);
      check("halt_flag", halted, 1'b1);
      check("halt_valid", instr_valid, 1'b0);
      for (int k = 0; k < 20; k++) begin
        mem_bus.mem_ack = 1'($urandom);
        @(negedge clk);
        check("halt_req", mem_bus.mem_req, 1'b0);
        check("halt_pc", pc, exp_pc[7:0]);
        check("halt_hold", halted, 1'b1);
      end
      mem_bus.mem_ack = 1'b0;
      return;
    end
    EscCP = esc;
    EscCondCP = cond;
    FonteCP = src;
    zero = z;
    ula_result = ula;
    @(negedge clk);
    for (int k = 0; k <= stalls; k++) begin
      check("exec_valid", instr_valid, 1'b0);
      check("exec_req", mem_bus.mem_req, 1'b0);
      check("exec_pc", pc, exp_pc[7:0]);
      stall = (k < stalls);
      if (k == stalls) mem_bus.mem_ack = 1'b0;
      @(negedge clk);
    end
    stall = 1'b0;
    exp_pc = model_pc(exp_pc, exp_ir, esc, cond, src, z, ula);
    check("exec_new_pc", pc, exp_pc[7:0]);
    check("exec_ir_kept", instr, exp_ir);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] d;
    d = 16'($urandom);
    if (d[15:12] == 4'hF) d[15:12] = 4'h0;
    return d;
  endfunction

  initial begin
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = 16'h0000;

    // Reset values
    #12;
    check("rst_req", mem_bus.mem_req, 1'b0);
    check("rst_pc", pc, 8'h00);
    check("rst_addr", mem_bus.mem_addr, 8'h00);
    check("rst_instr", instr, 16'h0000);
    check("rst_opcode", opcode, 4'h0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    check("idle_req", mem_bus.mem_req, 1'b0);
    @(negedge clk);

    run_instr(0, 16'h0123, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 0, 1'b0);
    run_instr(3, rand_instr(), 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 0, 1'b1);
    run_instr(0, 16'hB042, 1'b1, 1'b0, 2'b10, 1'b0, 8'h00, 0, 1'b0);
    run_instr(1, rand_instr(), 1'b0, 1'b1, 2'b01, 1'b1, 8'h10, 0, 1'b0);
    run_instr(0, rand_instr(), 1'b1, 1'b1, 2'b01, 1'b0, 8'h55, 0, 1'b0);
    run_instr(0, rand_instr(), 1'b0, 1'b0, 2'b10, 1'b1, 8'h77, 0, 1'b0);
    run_instr(0, 16'h20FF, 1'b1, 1'b0, 2'b10, 1'b0, 8'h00, 0, 1'b0);
    run_instr(0, rand_instr(), 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 2, 1'b1);
    run_instr(2, rand_instr(), 1'b1, 1'b0, 2'b11, 1'b0, 8'h99, 1, 1'b0);

    for (int n = 0; n < 16; n++) begin
      run_instr(int'($urandom_range(0, 3)), rand_instr(), 1'($urandom), 1'($urandom),
                2'($urandom), 1'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
                1'($urandom));
    end

    // Async reset in the middle of a fetch handshake
    run_instr(0, 16'h3033, 1'b1, 1'b0, 2'b10, 1'b0, 8'h00, 0, 1'b0);
    check("pre_rst_req", mem_bus.mem_req, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 16'h1234;
    #1;
    check("async_rst_req", mem_bus.mem_req, 1'b0);
    check("async_rst_pc", pc, 8'h00);
    check("async_rst_instr", instr, 16'h0000);
    exp_pc = 0;
    exp_ir = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    check("post_rst_ir", instr, 16'h0000);
    run_instr(1, rand_instr(), 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 0, 1'b0);
    run_instr(0, 16'hF000, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
